// File: rtl/baud_pkg.sv
// Shared types and helpers for the fractional baud-rate generator.
// Divisor values are fixed point: integer cycles plus frac/2^FRAC_W of a cycle.
package baud_pkg;

    localparam int DVSR_INT_W   = 16;
    localparam int DVSR_FRAC_W  = 4;
    localparam int RST_INT_DEF  = 27;
    localparam int RST_FRAC_DEF = 2;

    typedef struct packed {
        logic [DVSR_INT_W-1:0]  int_part;
        logic [DVSR_FRAC_W-1:0] frac_part;
    } dvsr_t;

    // Rounded clk_hz / (baud * ovs) in the fixed-point divisor format.
    function automatic dvsr_t calc_dvsr(input longint unsigned clk_hz,
                                        input longint unsigned baud,
                                        input longint unsigned ovs);
        longint unsigned den;
        longint unsigned q;
        dvsr_t           d;
        den = baud * ovs;
        d   = '0;
        if (den != 0) begin
            q           = ((clk_hz << DVSR_FRAC_W) + den / 2) / den;
            d.int_part  = DVSR_INT_W'(q >> DVSR_FRAC_W);
            d.frac_part = DVSR_FRAC_W'(q);
        end
        return d;
    endfunction

endpackage

// File: rtl/frac_accum.sv
// Fractional phase accumulator: adds frac once per period and registers the
// overflow as a carry that stretches the following period by one cycle.
module frac_accum #(
    parameter int FRAC_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              add_en,
    input  logic              clr,
    input  logic [FRAC_W-1:0] frac,
    output logic              carry,
    output logic [FRAC_W-1:0] acc
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            carry <= 1'b0;
            acc   <= '0;
        end else if (add_en) begin
            {carry, acc} <= {1'b0, acc} + {1'b0, frac};
        end
    end

endmodule

// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator: oversample tick, bit tick and phase index.
// Optional mid-bit tick output enabled by defining BAUD_GEN_MIDBIT_EN.
module baud_gen_frac
    import baud_pkg::*;
#(
    parameter int INT_W    = DVSR_INT_W,
    parameter int FRAC_W   = DVSR_FRAC_W,
    parameter int OVS      = 16,
    parameter int RST_INT  = RST_INT_DEF,
    parameter int RST_FRAC = RST_FRAC_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    resync,
    input  logic [INT_W-1:0]        dvsr_int,
    input  logic [FRAC_W-1:0]       dvsr_frac,
    input  logic                    dvsr_ld,
    output logic                    dvsr_pend,
    output logic                    tick_ovs,
    output logic                    tick_bit,
`ifdef BAUD_GEN_MIDBIT_EN
    output logic                    tick_mid,
`endif
    output logic [$clog2(OVS)-1:0]  ovs_idx
);

    localparam int IDX_W = $clog2(OVS);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(OVS - 1);
    localparam logic [IDX_W-1:0] IDX_MID_PRE = IDX_W'(OVS / 2 - 1);

    logic [INT_W-1:0]  act_int;
    logic [INT_W-1:0]  shd_int;
    logic [INT_W-1:0]  counter;
    logic [FRAC_W-1:0] act_frac;
    logic [FRAC_W-1:0] shd_frac;
    logic [FRAC_W-1:0] frac_acc;
    logic              carry;
    logic [INT_W:0]    period;
    logic              counting;
    logic              terminal;
    logic              apply;

    // >= rather than == so a smaller divisor applied while frozen cannot strand the counter.
    always_comb begin
        period   = {1'b0, act_int} + {{INT_W{1'b0}}, carry};
        counting = en && (act_int != '0);
        terminal = counting && ({1'b0, counter} >= (period - 1'b1));
        apply    = dvsr_pend && (terminal || resync || !en || (act_int == '0));
    end

    frac_accum #(
        .FRAC_W (FRAC_W)
    ) u_frac_accum (
        .clk    (clk),
        .rst    (rst),
        .add_en (terminal && !resync),
        .clr    (resync),
        .frac   (act_frac),
        .carry  (carry),
        .acc    (frac_acc)
    );

    // Shadow only matters once dvsr_pend is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (dvsr_ld) begin
            shd_int  <= dvsr_int;
            shd_frac <= dvsr_frac;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act_int   <= INT_W'(RST_INT);
            act_frac  <= FRAC_W'(RST_FRAC);
            counter   <= '0;
            ovs_idx   <= '0;
            dvsr_pend <= 1'b0;
            tick_ovs  <= 1'b0;
            tick_bit  <= 1'b0;
`ifdef BAUD_GEN_MIDBIT_EN
            tick_mid  <= 1'b0;
`endif
        end else begin
            if (apply) begin
                act_int  <= shd_int;
                act_frac <= shd_frac;
            end
            if (dvsr_ld) begin
                dvsr_pend <= 1'b1;
            end else if (apply) begin
                dvsr_pend <= 1'b0;
            end

            tick_ovs <= 1'b0;
            tick_bit <= 1'b0;
`ifdef BAUD_GEN_MIDBIT_EN
            tick_mid <= 1'b0;
`endif
            if (resync) begin
                counter <= '0;
                ovs_idx <= '0;
            end else if (terminal) begin
                counter  <= '0;
                ovs_idx  <= ovs_idx + 1'b1;
                tick_ovs <= 1'b1;
                tick_bit <= (ovs_idx == IDX_LAST);
`ifdef BAUD_GEN_MIDBIT_EN
                tick_mid <= (ovs_idx == IDX_MID_PRE);
`endif
            end else if (counting) begin
                counter <= counter + 1'b1;
            end else if (en) begin
                counter <= '0;
            end
        end
    end

`ifndef BAUD_GEN_MIDBIT_EN
    logic unused_mid;
    assign unused_mid = ^IDX_MID_PRE;
`endif

endmodule

// File: doc/baud_gen_frac.md
Name: baud_gen_frac

Overview:
- Parametrised fractional baud-rate generator for the UART datapath; successor to the integer-divisor tick generator.
- Produces an oversample tick (OVS per bit) from a fixed-point divisor (integer + fractional part), plus a derived bit tick and oversample phase index.
- Adds over the integer generator:
  - runtime divisor reload through a shadow register, without glitches;
  - a resync input that lets the UART receiver align the phase to a start-bit edge.

Parameters:
- INT_W, 16, width of the integer divisor part.
- FRAC_W, 4, width of the fractional divisor part (units of 1/2^FRAC_W cycle).
- OVS, 16, oversample ticks per bit; power of two, >= 4.
- RST_INT, 27, integer divisor value at reset (50 MHz, 115200 baud, x16).
- RST_FRAC, 2, fractional divisor value at reset.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  count enable; low freezes all state.
- resync  in  1  one-cycle pulse; restarts the phase.
- dvsr_int  in  INT_W  integer divisor for a pending load.
- dvsr_frac  in  FRAC_W  fractional divisor for a pending load.
- dvsr_ld  in  1  captures dvsr_int/dvsr_frac into the shadow register.
- dvsr_pend  out  1  shadow value captured but not yet applied.
- tick_ovs  out  1  one-cycle oversample tick.
- tick_bit  out  1  one-cycle bit tick, coincident with the tick_ovs at which ovs_idx wraps.
- ovs_idx  out  $clog2(OVS)  current oversample phase.

Behaviour:
Reset
- Single clock clk; reset rst is synchronous and active-high.
- On rst: act_int=RST_INT, act_frac=RST_FRAC; counter, frac_acc, carry, ovs_idx, dvsr_pend, tick_ovs, tick_bit all = 0.
- rst overrides every other input in the same cycle.

Counting
- Counting happens only when en=1 and act_int!=0.
- period = act_int + carry, where carry is the registered carry from the fractional accumulator.
- Terminal cycle: counter == period-1. On a terminal cycle:
  - counter <= 0;
  - {carry, frac_acc} <= frac_acc + act_frac, computed FRAC_W+1 bits wide;
  - tick_ovs <= 1 in the next cycle (registered, 1-cycle latency);
  - ovs_idx <= ovs_idx+1, wrapping modulo OVS.
- On any other counting cycle: counter increments; tick_ovs <= 0.
- tick_bit <= 1 together with the tick_ovs whose terminal moved ovs_idx from OVS-1 to 0.
- Average tick_ovs period = act_int + act_frac/2^FRAC_W cycles.
- act_int=1 with act_frac=0 gives tick_ovs on every cycle.
- act_int=0 stalls the generator: counter held at 0, no ticks.

en low
- All state is held and ticks are 0.
- Counting resumes from the held counter value.

Divisor reload
- dvsr_ld=1 captures the inputs into the shadow register and sets dvsr_pend.
- A later dvsr_ld before apply overwrites the shadow value (last write wins).
- Apply (shadow -> act_*, clear dvsr_pend) happens on:
  - the next terminal cycle, so the current period completes with the old divisor; or
  - the next cycle, if the generator is stalled (act_int=0) or en=0.
- frac_acc and carry are kept across an apply.
- If dvsr_ld and apply fall in the same cycle, the new value goes to the shadow and dvsr_pend stays 1.

resync
- Next cycle: counter=0, frac_acc=0, carry=0, ovs_idx=0.
- No tick is emitted for that cycle, even if it was a terminal cycle.
- A pending shadow value is applied at the same time.

Optional Feature:
- Macro BAUD_GEN_MIDBIT_EN.
- Defined: adds output tick_mid (1 bit), which pulses with the tick_ovs at which ovs_idx changes from OVS/2-1 to OVS/2 (the mid-bit sample point for the receiver). Reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package baud_pkg holds:
  - typedef dvsr_t, a struct {int part, frac part} sized by the defaults;
  - localparams for the reset divisor values;
  - a function computing the divisor from clock frequency, baud rate and OVS.
- Sub-module frac_accum is natural: accumulator plus carry register, with inputs add_en, frac, clr and outputs carry, acc.

Test Plan:
- Reset then en=1, defaults 27/2 -> tick_ovs every 27 cycles, except every 8th period is 28 cycles. Over 16 ticks: exactly 434 cycles (27.125 x 16). tick_bit on the 16th tick.
- dvsr_int=4, frac=8, FRAC_W=4 -> tick intervals alternate 4 and 5 cycles.
- dvsr_int=1, frac=0 -> tick_ovs high every cycle; tick_bit every 16 cycles.
- Load 10/0 mid-period while act=27/2 -> current period ends at 27 or 28 cycles; the following period is 10 cycles; dvsr_pend clears on the terminal cycle.
- resync at counter=13 -> counter=0 next cycle; the first tick comes 27 cycles after the resync cycle; ovs_idx=0.
- en low for 5 cycles at counter=20 -> tick is delayed exactly 5 cycles. Separately, rst during counting -> all outputs 0 next cycle.
